// File: rtl/bp_cfg_bus_loader.sv
// Boot-time config-bus master: after reset it freezes every core, streams CCE microcode
// from a ROM into each CCE, sets the CCE mode and finally unfreezes all cores.
module bp_cfg_bus_loader #(
  parameter int num_core_p              = 1,
  parameter int num_cce_instr_ram_els_p = 256,
  parameter int cfg_core_width_p        = 8,
  parameter int cfg_addr_width_p        = 16,
  parameter int cfg_data_width_p        = 32,
  parameter int cce_mode_p              = 1,
  localparam int instr_w_lp = (num_cce_instr_ram_els_p > 1) ? $clog2(num_cce_instr_ram_els_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [cfg_core_width_p-1:0] cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic [instr_w_lp-1:0]       rom_addr_o,
  input  logic [cfg_data_width_p-1:0] rom_data_i,
  output logic                        done_o
);

  localparam int core_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

  localparam logic [cfg_addr_width_p-1:0] freeze_addr_lp = cfg_addr_width_p'(16'h0001);
  localparam logic [cfg_addr_width_p-1:0] mode_addr_lp   = cfg_addr_width_p'(16'h0002);
  localparam logic [cfg_addr_width_p-1:0] ucode_base_lp  = cfg_addr_width_p'(16'h8000);

  localparam logic [core_w_lp-1:0]  last_core_lp  = core_w_lp'(num_core_p - 1);
  localparam logic [instr_w_lp-1:0] last_instr_lp = instr_w_lp'(num_cce_instr_ram_els_p - 1);

  typedef enum logic [2:0] {
    e_freeze,
    e_fetch,
    e_ucode,
    e_mode,
    e_unfreeze,
    e_done
  } state_e;

  state_e                state_r;
  logic [core_w_lp-1:0]  core_cnt_r;
  logic [instr_w_lp-1:0] instr_cnt_r;

  logic                  accept;
  logic                  last_core;
  logic                  last_instr;
  logic [core_w_lp-1:0]  core_nxt;

  function automatic logic [cfg_core_width_p-1:0] core_id(input logic [core_w_lp-1:0] c);
    return cfg_core_width_p'(c);
  endfunction

  function automatic logic [cfg_addr_width_p-1:0] ucode_addr(input logic [instr_w_lp-1:0] i);
    return ucode_base_lp + cfg_addr_width_p'(i);
  endfunction

  assign accept     = cfg_v_o & cfg_ready_i;
  assign last_core  = (core_cnt_r == last_core_lp);
  assign last_instr = (instr_cnt_r == last_instr_lp);
  assign core_nxt   = core_cnt_r + core_w_lp'(1);

  // The instruction counter doubles as the ROM address, so the ROM sees the new
  // address for the whole e_fetch cycle and its data is sampled at the following edge.
  assign rom_addr_o = instr_cnt_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= e_freeze;
      core_cnt_r  <= '0;
      instr_cnt_r <= '0;
      cfg_v_o     <= 1'b0;
      cfg_core_o  <= '0;
      cfg_addr_o  <= '0;
      cfg_data_o  <= '0;
      done_o      <= 1'b0;
    end else begin
      case (state_r)
        e_freeze: begin
          if (!cfg_v_o) begin
            cfg_v_o    <= 1'b1;
            cfg_core_o <= core_id(core_cnt_r);
            cfg_addr_o <= freeze_addr_lp;
            cfg_data_o <= cfg_data_width_p'(1);
          end else if (accept) begin
            if (last_core) begin
              core_cnt_r <= '0;
              cfg_v_o    <= 1'b0;
              state_r    <= e_fetch;
            end else begin
              core_cnt_r <= core_nxt;
              cfg_core_o <= core_id(core_nxt);
            end
          end
        end

        e_fetch: begin
          cfg_v_o    <= 1'b1;
          cfg_core_o <= core_id(core_cnt_r);
          cfg_addr_o <= ucode_addr(instr_cnt_r);
          cfg_data_o <= rom_data_i;
          state_r    <= e_ucode;
        end

        e_ucode: begin
          if (accept) begin
            cfg_v_o <= 1'b0;
            state_r <= e_fetch;
            if (last_instr) begin
              instr_cnt_r <= '0;
              if (last_core) begin
                core_cnt_r <= '0;
                cfg_v_o    <= 1'b1;
                cfg_core_o <= core_id('0);
                cfg_addr_o <= mode_addr_lp;
                cfg_data_o <= cfg_data_width_p'(cce_mode_p);
                state_r    <= e_mode;
              end else begin
                core_cnt_r <= core_nxt;
              end
            end else begin
              instr_cnt_r <= instr_cnt_r + instr_w_lp'(1);
            end
          end
        end

        e_mode: begin
          if (accept) begin
            if (last_core) begin
              core_cnt_r <= '0;
              cfg_core_o <= core_id('0);
              cfg_addr_o <= freeze_addr_lp;
              cfg_data_o <= '0;
              state_r    <= e_unfreeze;
            end else begin
              core_cnt_r <= core_nxt;
              cfg_core_o <= core_id(core_nxt);
            end
          end
        end

        e_unfreeze: begin
          if (accept) begin
            if (last_core) begin
              core_cnt_r <= '0;
              cfg_v_o    <= 1'b0;
              done_o     <= 1'b1;
              state_r    <= e_done;
            end else begin
              core_cnt_r <= core_nxt;
              cfg_core_o <= core_id(core_nxt);
            end
          end
        end

        default: begin
          cfg_v_o <= 1'b0;
          done_o  <= 1'b1;
          state_r <= e_done;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cfg_bus_loader.sv
// Scoreboard bench for bp_cfg_bus_loader: expected write trace built from the phase
// rules, monitor pops and compares each accepted write and checks stall stability.
module tb_bp_cfg_bus_loader;

  localparam int NC = 2;
  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cfg_ready_i = 1'b0;
  logic        cfg_v_o;
  logic [7:0]  cfg_core_o;
  logic [15:0] cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic [1:0]  rom_addr_o;
  logic [31:0] rom_data_i;
  logic        done_o;

  logic [31:0] rom [NI];
  assign rom_data_i = rom[rom_addr_o];

  bp_cfg_bus_loader #(
    .num_core_p              (NC),
    .num_cce_instr_ram_els_p (NI),
    .cfg_core_width_p        (8),
    .cfg_addr_width_p        (16),
    .cfg_data_width_p        (32),
    .cce_mode_p              (1)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .cfg_v_o     (cfg_v_o),
    .cfg_ready_i (cfg_ready_i),
    .cfg_core_o  (cfg_core_o),
    .cfg_addr_o  (cfg_addr_o),
    .cfg_data_o  (cfg_data_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  core;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vecs = 0;
  int  errs = 0;
  int  accepts = 0;
  int  cyc = 0;
  int  last_acc_cyc = -10;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_wr(input int c, input logic [15:0] a, input logic [31:0] d);
    wr_t w;
    w.core = 8'(c);
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endfunction

  // Reference trace: freeze all, ucode per core, mode all, unfreeze all.
  function automatic void build_expected();
    exp_q.delete();
    for (int c = 0; c < NC; c++) push_wr(c, 16'h0001, 32'd1);
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < NI; i++) push_wr(c, 16'h8000 + 16'(i), rom[i]);
    for (int c = 0; c < NC; c++) push_wr(c, 16'h0002, 32'd1);
    for (int c = 0; c < NC; c++) push_wr(c, 16'h0001, 32'd0);
  endfunction

  // Monitor: samples on the falling edge, between active edges.
  initial begin
    logic stall_pend;
    logic done_prev;
    wr_t  held;
    wr_t  cur;
    wr_t  e;
    stall_pend = 1'b0;
    done_prev  = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_i) begin
        stall_pend = 1'b0;
        done_prev  = 1'b0;
      end else begin
        cur = {cfg_core_o, cfg_addr_o, cfg_data_o};
        if (stall_pend) begin
          chk("stall_valid_held", cfg_v_o, 1'b1);
          chk("stall_payload_held", cur, held);
        end
        if (cfg_v_o && cfg_ready_i) begin
          chk("write_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_core", cur.core, e.core);
            chk("wr_addr", cur.addr, e.addr);
            chk("wr_data", cur.data, e.data);
          end
          accepts++;
          last_acc_cyc = cyc;
        end
        if (done_o && !done_prev) begin
          chk("done_one_cycle_after_last_accept", cyc - last_acc_cyc, 1);
          chk("done_queue_empty", exp_q.size(), 0);
        end
        stall_pend = cfg_v_o && !cfg_ready_i;
        held       = cur;
        done_prev  = done_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input bit fixed_rom);
    reset_i = 1'b1;
    tick();
    tick();
    chk("rst_cfg_v", cfg_v_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_core", cfg_core_o, 8'h0);
    chk("rst_addr", cfg_addr_o, 16'h0);
    chk("rst_data", cfg_data_o, 32'h0);
    chk("rst_rom_addr", rom_addr_o, 2'd0);
    for (int i = 0; i < NI; i++) rom[i] = fixed_rom ? (32'hA0 + 32'(i)) : $urandom;
    build_expected();
    accepts = 0;
    reset_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd_ready, output int n);
    n = 0;
    while (!done_o && n < budget) begin
      tick();
      if (rnd_ready) cfg_ready_i = 1'($urandom_range(0, 1));
      n++;
    end
    chk("done_reached", done_o, 1'b1);
    chk("write_count", accepts, NC * (NI + 3));
  endtask

  initial begin
    int n;
    for (int i = 0; i < NI; i++) rom[i] = 32'h0;

    // Full-throughput run with the fixed ROM image.
    cfg_ready_i = 1'b1;
    start_run(1'b1);
    wait_done(500, 1'b0, n);
    chk("cycles_to_done", n, 1 + 3 * NC + 2 * NC * NI);

    // Random backpressure with random microcode.
    start_run(1'b0);
    cfg_ready_i = 1'($urandom_range(0, 1));
    wait_done(2000, 1'b1, n);

    // Long stall on the first freeze write.
    cfg_ready_i = 1'b0;
    start_run(1'b0);
    repeat (20) tick();
    chk("stall_freeze_v", cfg_v_o, 1'b1);
    chk("stall_freeze_addr", cfg_addr_o, 16'h0001);
    chk("stall_freeze_core", cfg_core_o, 8'h0);
    chk("stall_freeze_data", cfg_data_o, 32'h1);
    chk("stall_no_accepts", accepts, 0);
    cfg_ready_i = 1'b1;
    wait_done(500, 1'b0, n);

    // Reset pulse while presenting ucode instruction 2 of core 0.
    cfg_ready_i = 1'b1;
    start_run(1'b0);
    n = 0;
    while (!(cfg_v_o && cfg_addr_o == 16'h8002) && n < 200) begin
      tick();
      n++;
    end
    chk("reached_ucode_instr2", cfg_v_o && cfg_addr_o == 16'h8002, 1'b1);
    reset_i = 1'b1;
    tick();
    chk("abort_cfg_v", cfg_v_o, 1'b0);
    chk("abort_done", done_o, 1'b0);
    build_expected();
    accepts = 0;
    reset_i = 1'b0;
    wait_done(500, 1'b0, n);

    // Terminal state must ignore the bus and ROM.
    for (int k = 0; k < 50; k++) begin
      tick();
      cfg_ready_i = 1'($urandom_range(0, 1));
      for (int i = 0; i < NI; i++) rom[i] = $urandom;
      chk("post_done_v", cfg_v_o, 1'b0);
      chk("post_done_done", done_o, 1'b1);
    end
    chk("post_done_no_writes", accepts, NC * (NI + 3));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
